// File: rtl/vx_norm_shift_if.sv
// Bus bundle for the mantissa normalizer: input beat, output beat and both handshakes.
interface vx_norm_shift_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned TAG_W = 1
);
  logic             valid_in;
  logic             ready_in;
  logic [WIDTH-1:0] data_in;
  logic [EXP_W-1:0] exp_in;
  logic [TAG_W-1:0] tag_in;
  logic             valid_out;
  logic             ready_out;
  logic [WIDTH-1:0] data_out;
  logic [EXP_W-1:0] exp_out;
  logic [TAG_W-1:0] tag_out;
  logic             zero_out;
  logic             denorm_out;

  modport master (
    output valid_in, data_in, exp_in, tag_in, ready_out,
    input  ready_in, valid_out, data_out, exp_out, tag_out, zero_out, denorm_out
  );

  modport slave (
    input  valid_in, data_in, exp_in, tag_in, ready_out,
    output ready_in, valid_out, data_out, exp_out, tag_out, zero_out, denorm_out
  );
endinterface

// File: rtl/vx_norm_shift.sv
// Two-stage mantissa normalizer: S1 registers the beat and its leading-zero count,
// S2 shifts left by min(lz, exp) so the biased exponent never underflows.
module vx_norm_shift #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned TAG_W = 1
) (
  input  logic            clk,
  input  logic            reset,
  vx_norm_shift_if.slave  bus
);
  localparam int unsigned LZ_W  = $clog2(WIDTH);
  localparam int unsigned CMP_W = ((LZ_W > EXP_W) ? LZ_W : EXP_W) + 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [EXP_W-1:0] s1_exp;
  logic [TAG_W-1:0] s1_tag;
  logic [LZ_W-1:0]  s1_lz;
  logic             s1_zero;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [EXP_W-1:0] s2_exp;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_zero;
  logic             s2_denorm;

  logic             en1;
  logic             en2;

  logic [LZ_W-1:0]  lz_c;
  logic             nz_c;
  logic [CMP_W-1:0] lz_x;
  logic [CMP_W-1:0] exp_x;
  logic [CMP_W-1:0] shamt;
  logic             clamp;
  logic [WIDTH-1:0] data_c;
  logic [EXP_W-1:0] exp_c;
  logic             denorm_c;

  // Stall chain: a stage may load when the stage downstream of it is free or draining.
  assign en2 = ~s2_valid | bus.ready_out;
  assign en1 = ~s1_valid | en2;

  // Leading-zero count; the highest set bit wins because it is visited last.
  always_comb begin
    lz_c = '0;
    nz_c = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bus.data_in[i]) begin
        lz_c = LZ_W'(int'(WIDTH) - 1 - i);
        nz_c = 1'b1;
      end
    end
  end

  // Clamped shift, compared one bit wider than either operand.
  always_comb begin
    lz_x     = CMP_W'(s1_lz);
    exp_x    = CMP_W'(s1_exp);
    clamp    = lz_x > exp_x;
    shamt    = clamp ? exp_x : lz_x;
    data_c   = s1_data << shamt;
    exp_c    = s1_exp - EXP_W'(shamt);
    denorm_c = clamp;
    if (s1_zero) begin
      data_c   = '0;
      exp_c    = '0;
      denorm_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_exp    <= '0;
      s1_tag    <= '0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_exp    <= '0;
      s2_tag    <= '0;
      s2_zero   <= 1'b0;
      s2_denorm <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid <= bus.valid_in;
        s1_data  <= bus.data_in;
        s1_exp   <= bus.exp_in;
        s1_tag   <= bus.tag_in;
        s1_lz    <= lz_c;
        s1_zero  <= ~nz_c;
      end
      if (en2) begin
        s2_valid  <= s1_valid;
        s2_data   <= data_c;
        s2_exp    <= exp_c;
        s2_tag    <= s1_tag;
        s2_zero   <= s1_zero;
        s2_denorm <= denorm_c;
      end
    end
  end

  assign bus.ready_in   = en1;
  assign bus.valid_out  = s2_valid;
  assign bus.data_out   = s2_data;
  assign bus.exp_out    = s2_exp;
  assign bus.tag_out    = s2_tag;
  assign bus.zero_out   = s2_zero;
  assign bus.denorm_out = s2_denorm;
endmodule

// File: tb/tb_vx_norm_shift.sv
// Directed bench for vx_norm_shift (WIDTH=8, EXP_W=8, TAG_W=2) with an in-order output scoreboard.
module tb_vx_norm_shift;
  typedef struct {
    logic [7:0] di;
    logic [7:0] ei;
    logic [1:0] ti;
    logic [7:0] d;
    logic [7:0] e;
    logic [1:0] t;
    logic       z;
    logic       dn;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  vec_t exp_q[$];
  int   in_cyc[$];
  int   out_cyc[$];

  logic       stall_prev = 1'b0;
  logic [7:0] held_d;
  logic [7:0] held_e;
  logic [1:0] held_t;
  logic       held_z;
  logic       held_dn;

  vx_norm_shift_if #(.WIDTH(8), .EXP_W(8), .TAG_W(2)) bus ();

  vx_norm_shift #(.WIDTH(8), .EXP_W(8), .TAG_W(2)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Present one beat and hold it until accepted; returns how many cycles it waited.
  task automatic send(input vec_t v, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = v.di;
    bus.exp_in   = v.ei;
    bus.tag_in   = v.ti;
    while (!acc && waited < 64) begin
      @(negedge clk);
      if (bus.ready_in) acc = 1'b1;
      else waited++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    else begin
      exp_q.push_back(v);
      in_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: in-order scoreboard plus hold-while-stalled check.
  always @(negedge clk) begin
    vec_t b;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", bus.valid_out, 1);
        chk("hold_data", bus.data_out, held_d);
        chk("hold_exp", bus.exp_out, held_e);
        chk("hold_tag", bus.tag_out, held_t);
        chk("hold_flags", {bus.zero_out, bus.denorm_out}, {held_z, held_dn});
      end
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("out_data", bus.data_out, b.d);
          chk("out_exp", bus.exp_out, b.e);
          chk("out_tag", bus.tag_out, b.t);
          chk("out_zero", bus.zero_out, b.z);
          chk("out_denorm", bus.denorm_out, b.dn);
          out_cyc.push_back(cyc);
        end
      end
      stall_prev = bus.valid_out && !bus.ready_out;
      held_d  = bus.data_out;
      held_e  = bus.exp_out;
      held_t  = bus.tag_out;
      held_z  = bus.zero_out;
      held_dn = bus.denorm_out;
    end
  end

  vec_t vecs[10] = '{
    '{8'h10, 8'd10,  2'd2, 8'h80, 8'd7,   2'd2, 1'b0, 1'b0},
    '{8'h01, 8'd3,   2'd1, 8'h08, 8'd0,   2'd1, 1'b0, 1'b1},
    '{8'h01, 8'd7,   2'd0, 8'h80, 8'd0,   2'd0, 1'b0, 1'b0},
    '{8'h00, 8'd5,   2'd3, 8'h00, 8'd0,   2'd3, 1'b1, 1'b0},
    '{8'h9C, 8'd0,   2'd1, 8'h9C, 8'd0,   2'd1, 1'b0, 1'b0},
    '{8'h10, 8'd0,   2'd2, 8'h10, 8'd0,   2'd2, 1'b0, 1'b1},
    '{8'hFF, 8'd255, 2'd3, 8'hFF, 8'd255, 2'd3, 1'b0, 1'b0},
    '{8'h03, 8'd2,   2'd0, 8'h0C, 8'd0,   2'd0, 1'b0, 1'b1},
    '{8'h40, 8'd1,   2'd1, 8'h80, 8'd0,   2'd1, 1'b0, 1'b0},
    '{8'h00, 8'd0,   2'd2, 8'h00, 8'd0,   2'd2, 1'b1, 1'b0}
  };

  vec_t stall_vecs[5] = '{
    '{8'h01, 8'd20, 2'd0, 8'h80, 8'd13, 2'd0, 1'b0, 1'b0},
    '{8'h02, 8'd20, 2'd1, 8'h80, 8'd14, 2'd1, 1'b0, 1'b0},
    '{8'h03, 8'd20, 2'd2, 8'hC0, 8'd14, 2'd2, 1'b0, 1'b0},
    '{8'h04, 8'd20, 2'd3, 8'h80, 8'd15, 2'd3, 1'b0, 1'b0},
    '{8'h05, 8'd20, 2'd0, 8'hA0, 8'd15, 2'd0, 1'b0, 1'b0}
  };

  initial begin
    int   w;
    vec_t v;
    bus.valid_in  = 1'b0;
    bus.data_in   = '0;
    bus.exp_in    = '0;
    bus.tag_in    = '0;
    bus.ready_out = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_exp", bus.exp_out, 0);
    chk("rst_tag", bus.tag_out, 0);
    chk("rst_flags", {bus.zero_out, bus.denorm_out}, 0);
    chk("rst_ready_in", bus.ready_in, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat with latency check
    send(vecs[0], w);
    @(negedge clk);
    chk("lat_early", bus.valid_out, 0);
    @(negedge clk);
    chk("lat_valid", bus.valid_out, 1);
    drain();

    // Boundary vectors back to back
    for (int i = 1; i < 10; i++) send(vecs[i], w);
    drain();

    // Stall: two beats fill the pipe, then ready_in must drop
    bus.ready_out = 1'b0;
    send(stall_vecs[0], w);
    send(stall_vecs[1], w);
    bus.valid_in = 1'b1;
    bus.data_in  = stall_vecs[2].di;
    bus.exp_in   = stall_vecs[2].ei;
    bus.tag_in   = stall_vecs[2].ti;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_ready_in", bus.ready_in, 0);
      chk("full_valid", bus.valid_out, 1);
      chk("full_data", bus.data_out, 8'h80);
      chk("full_exp", bus.exp_out, 8'd13);
      @(posedge clk);
      #1;
    end
    bus.ready_out = 1'b1;
    for (int i = 2; i < 5; i++) send(stall_vecs[i], w);
    drain();

    // Full-throughput stream
    in_cyc.delete();
    out_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      v.di = 8'h01 << (i % 8);
      v.ei = 8'd10;
      v.ti = 2'(i % 4);
      v.d  = 8'h80;
      v.e  = 8'(3 + (i % 8));
      v.t  = 2'(i % 4);
      v.z  = 1'b0;
      v.dn = 1'b0;
      send(v, w);
      chk("stream_ready_in", w, 0);
    end
    drain();
    chk("stream_count", out_cyc.size(), 16);
    if (out_cyc.size() == 16 && in_cyc.size() == 16) begin
      chk("stream_span", out_cyc[15] - out_cyc[0], 15);
      chk("stream_latency", out_cyc[0] - in_cyc[0], 2);
    end

    // Reset with two beats in flight
    bus.ready_out = 1'b0;
    send(vecs[1], w);
    send(vecs[2], w);
    @(negedge clk);
    chk("inflight_valid", bus.valid_out, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_valid", bus.valid_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ready_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", bus.valid_out, 0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
